// File: rtl/configure.sv
// rtl/configure.sv - uart_rx shared types: FSM states, register offsets, STATUS bits (UART_RX_PARITY_EN adds PARITY)
package configure;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;
`endif

    localparam logic [31:0] REG_DATA   = 32'h0;
    localparam logic [31:0] REG_STATUS = 32'h4;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVR       = 2;
    localparam int STAT_FERR      = 3;
    localparam int STAT_PERR      = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO with wrap-bit pointers
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_pop;
    logic        do_push;

    // A push into a full FIFO still lands when a pop frees the head slot in the same cycle.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance; the extra MSB distinguishes full from empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, no reset needed since empty gates every read.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with FIFO and bus registers; UART_RX_PARITY_EN enables even parity
module uart_rx
    import configure::*;
#(
    parameter int CLKS_PER_BIT = 100,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    input  logic        rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    rx_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shift, shift_n;
    logic        rx_meta, rx_sync;
    logic        push, ferr_set, perr_set;
    logic        ovr, ferr, perr;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_data;
    logic        accept, is_write, is_status, pop, ovr_set;
    logic [2:0]  w1c;
    logic [31:0] rd_val;
    logic        unused_bits;

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n;
`endif

    assign unused_bits = ^{uart_addr[31:3], uart_addr[1:0], uart_wdata[31:5],
                           uart_wdata[1:0], uart_wstrb[3:1]};

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Receive FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_n;
`endif
        end
    end

    // Receive FSM next state: each bit is sampled mid-cell when the counter reaches zero.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bit_n    = bit_idx;
        shift_n  = shift;
        push     = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
`endif
        case (state)
            ST_IDLE: begin
                if (!rx_sync) begin
                    state_n = ST_START;
                    cnt_n   = HALF_BIT;
                end
            end
            ST_START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (!rx_sync) begin
                    state_n = ST_DATA;
                    cnt_n   = FULL_BIT;
                    bit_n   = 3'd0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shift_n = {rx_sync, shift[7:1]};
                    cnt_n   = FULL_BIT;
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    par_bad_n = (^shift) ^ rx_sync;
                    cnt_n     = FULL_BIT;
                    state_n   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = ST_IDLE;
                    if (!rx_sync) begin
                        ferr_set = 1'b1;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        if (par_bad) perr_set = 1'b1;
                        else         push     = 1'b1;
`else
                        push = 1'b1;
`endif
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (shift),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign accept    = uart_valid && !uart_ready;
    assign is_write  = |uart_wstrb;
    assign is_status = (uart_addr[2] == REG_STATUS[2]);
    assign pop       = accept && !uart_instr && !is_write && !is_status && !fifo_empty;
    assign ovr_set   = push && fifo_full && !pop;
    assign w1c       = (accept && !uart_instr && is_write && is_status && uart_wstrb[0])
                       ? uart_wdata[4:2] : 3'b000;

    // Read data mux; fetches and writes return zero.
    always_comb begin
        rd_val = 32'h0;
        if (!uart_instr && !is_write) begin
            if (is_status) begin
                rd_val[STAT_NOT_EMPTY] = !fifo_empty;
                rd_val[STAT_FULL]      = fifo_full;
                rd_val[STAT_OVR]       = ovr;
                rd_val[STAT_FERR]      = ferr;
                rd_val[STAT_PERR]      = perr;
            end else if (!fifo_empty) begin
                rd_val = {24'h0, fifo_data};
            end
        end
    end

    // Sticky error flags; a same-cycle set beats the W1C clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
            perr <= 1'b0;
        end else begin
            ovr  <= ovr_set  | (ovr  & ~w1c[0]);
            ferr <= ferr_set | (ferr & ~w1c[1]);
            perr <= perr_set | (perr & ~w1c[2]);
        end
    end

    // Bus response: one-cycle ready after acceptance, data captured at acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            uart_ready <= 1'b0;
            uart_rdata <= 32'h0;
        end else begin
            uart_ready <= accept;
            uart_rdata <= accept ? rd_val : 32'h0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_uart_rx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        reset, clock;
    logic        uart_valid, uart_instr;
    logic [31:0] uart_addr, uart_wdata, uart_rdata;
    logic [3:0]  uart_wstrb;
    logic        uart_ready, rx;

    int n_chk  = 0;
    int n_fail = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .reset      (reset),
        .clock      (clock),
        .uart_valid (uart_valid),
        .uart_instr (uart_instr),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .rx         (rx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef enum logic [2:0] {OP_FRAME, OP_BADSTOP, OP_RDDATA, OP_RDSTAT, OP_WRSTAT} op_t;
    typedef struct {
        op_t         op;
        logic [7:0]  val;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        @(negedge clock);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clock);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ !par_ok;
        repeat (CPB) @(negedge clock);
`endif
        rx = stop_ok;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                       input logic instr, output logic [31:0] rd);
        @(negedge clock);
        uart_valid = 1'b1;
        uart_addr  = addr;
        uart_wstrb = strb;
        uart_wdata = wd;
        uart_instr = instr;
        @(posedge clock);
        #1;
        check("ready_pulse", uart_ready, 1);
        rd = uart_rdata;
        @(negedge clock);
        uart_valid = 1'b0;
        uart_wstrb = 4'h0;
        uart_instr = 1'b0;
        @(posedge clock);
        #1;
        check("ready_one_cycle", uart_ready, 0);
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus(addr, 4'h0, 32'h0, 1'b0, rd);
        check(name, rd, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        bus(addr, 4'h1, wd, 1'b0, rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  mq[$];
        logic        m_ovr, m_ferr;
        logic [7:0]  d;
        logic        stop_ok;
        logic [31:0] exp_stat, mask;

        reset = 1'b0; rx = 1'b1; uart_valid = 1'b0; uart_instr = 1'b0;
        uart_addr = 32'h0; uart_wdata = 32'h0; uart_wstrb = 4'h0;
        repeat (3) @(negedge clock);
        check("reset_ready", uart_ready, 0);
        check("reset_rdata", uart_rdata, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("post_reset_ready", uart_ready, 0);
        rd_check("reset_status", 32'h4, 32'h0);

        // Directed table: basic frame, overflow, framing error, W1C.
        tbl.push_back('{OP_FRAME,   8'hA5, 32'h0});
        tbl.push_back('{OP_RDDATA,  8'h00, 32'h0000_00A5});
        tbl.push_back('{OP_RDSTAT,  8'h00, 32'h0});
        for (int i = 1; i <= 5; i++) tbl.push_back('{OP_FRAME, 8'(i), 32'h0});
        tbl.push_back('{OP_RDSTAT,  8'h00, 32'h7});
        for (int i = 1; i <= 4; i++) tbl.push_back('{OP_RDDATA, 8'h00, 32'(i)});
        tbl.push_back('{OP_RDDATA,  8'h00, 32'h0});
        tbl.push_back('{OP_RDSTAT,  8'h00, 32'h4});
        tbl.push_back('{OP_WRSTAT,  8'h04, 32'h0});
        tbl.push_back('{OP_RDSTAT,  8'h00, 32'h0});
        tbl.push_back('{OP_BADSTOP, 8'h5A, 32'h0});
        tbl.push_back('{OP_RDSTAT,  8'h00, 32'h8});
        tbl.push_back('{OP_RDDATA,  8'h00, 32'h0});
        tbl.push_back('{OP_WRSTAT,  8'h08, 32'h0});
        tbl.push_back('{OP_RDSTAT,  8'h00, 32'h0});

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_FRAME:   send_frame(tbl[i].val, 1'b1, 1'b1);
                OP_BADSTOP: send_frame(tbl[i].val, 1'b0, 1'b1);
                OP_RDDATA:  rd_check($sformatf("tbl%0d_data", i), 32'h0, tbl[i].exp);
                OP_RDSTAT:  rd_check($sformatf("tbl%0d_status", i), 32'h4, tbl[i].exp);
                OP_WRSTAT:  wr(32'h4, {24'h0, tbl[i].val});
                default:    ;
            endcase
        end

        // One-cycle glitch on rx must not start a frame.
        @(negedge clock);
        rx = 1'b0;
        @(negedge clock);
        rx = 1'b1;
        repeat (20) @(negedge clock);
        rd_check("glitch_status", 32'h4, 32'h0);

        // Fetch requests and DATA writes leave the FIFO untouched.
        send_frame(8'h77, 1'b1, 1'b1);
        bus(32'h0, 4'h0, 32'h0, 1'b1, rd);
        check("instr_rdata", rd, 0);
        bus(32'h0, 4'hF, 32'hFFFF_FFFF, 1'b0, rd);
        check("write_data_rdata", rd, 0);
        rd_check("instr_status", 32'h4, 32'h1);
        rd_check("instr_data", 32'h0, 32'h77);

        // Valid held high: every other cycle is accepted.
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        @(negedge clock);
        uart_valid = 1'b1; uart_addr = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("held_ready%0d", k), uart_ready, (k % 2 == 0) ? 1 : 0);
            if (k == 0) check("held_data0", uart_rdata, 32'h11);
            if (k == 2) check("held_data2", uart_rdata, 32'h22);
        end
        @(negedge clock);
        uart_valid = 1'b0;
        rd_check("held_status", 32'h4, 32'h0);

        // Full FIFO, DATA read lands in the same cycle as the fifth push.
        for (int i = 1; i <= 4; i++) send_frame(8'h40 + 8'(i), 1'b1, 1'b1);
        fork
            send_frame(8'h45, 1'b1, 1'b1);
            begin
                @(negedge clock);
                repeat (CPB * FRAME_BITS) @(posedge clock);
                bus(32'h0, 4'h0, 32'h0, 1'b0, rd);
                check("same_cycle_data", rd, 32'h41);
            end
        join
        rd_check("same_cycle_status", 32'h4, 32'h3);
        for (int i = 2; i <= 5; i++) rd_check($sformatf("same_cycle_rd%0d", i), 32'h0, 32'h40 + i);
        rd_check("same_cycle_empty", 32'h4, 32'h0);

        // Reset in the middle of a frame and of a response.
        @(negedge clock);
        rx = 1'b0;
        repeat (CPB * 3) @(negedge clock);
        reset = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        uart_valid = 1'b1; uart_addr = 32'h4;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("reset_kills_ready", uart_ready, 0);
        uart_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("no_spurious_ready", uart_ready, 0);
        send_frame(8'h3C, 1'b1, 1'b1);
        rd_check("after_reset_data", 32'h0, 32'h3C);
        rd_check("after_reset_empty", 32'h0, 32'h0);
        rd_check("after_reset_status", 32'h4, 32'h0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h3C, 1'b1, 1'b0);
        rd_check("perr_status", 32'h4, 32'h10);
        rd_check("perr_empty", 32'h0, 32'h0);
        wr(32'h4, 32'h10);
        rd_check("perr_cleared", 32'h4, 32'h0);
`endif

        // Randomized frames checked against a queue model.
        m_ovr = 1'b0; m_ferr = 1'b0;
        for (int it = 0; it < 24; it++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            send_frame(d, stop_ok, 1'b1);
            if (!stop_ok)              m_ferr = 1'b1;
            else if (mq.size() == DEPTH) m_ovr = 1'b1;
            else                        mq.push_back(d);
            for (int r = $urandom_range(0, 2); r > 0; r--) begin
                if (mq.size() > 0) rd_check($sformatf("rand%0d_data", it), 32'h0, {24'h0, mq.pop_front()});
                else               rd_check($sformatf("rand%0d_data", it), 32'h0, 32'h0);
            end
            exp_stat = {27'h0, 1'b0, m_ferr, m_ovr, mq.size() == DEPTH, mq.size() != 0};
            rd_check($sformatf("rand%0d_status", it), 32'h4, exp_stat);
            if ($urandom_range(0, 3) == 0) begin
                mask = 32'($urandom_range(0, 7)) << 2;
                wr(32'h4, mask);
                if (mask[2]) m_ovr  = 1'b0;
                if (mask[3]) m_ferr = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
